// File: rtl/note_disp_pkg.sv
// Shared types and constants for the note-highway scroller.
package note_disp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [2:0] PLAY_MODE = 3'd2;

endpackage

// File: rtl/note_window_lane.sv
// One lane of the note highway: window extraction, consumed flag, LED register and judge pulses.
module note_window_lane #(
  parameter int SONG_LEN = 32,
  parameter int WIN      = 7,
  parameter int IDX_W    = $clog2(SONG_LEN + WIN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    idx,
  input  logic [SONG_LEN-1:0] song_bits,
  input  logic                hit,
  input  logic                advance,
  input  logic                clear,
  input  logic                show,
  output logic [WIN-1:0]      display,
  output logic                hit_ok,
  output logic                hit_bad,
  output logic                miss
);

  localparam int SP_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam logic [IDX_W:0] LO = (IDX_W+1)'(WIN - 1);
  localparam logic [IDX_W:0] HI = (IDX_W+1)'(SONG_LEN + WIN - 1);

  logic [WIN-1:0] win;
  logic [IDX_W:0] pos;
  logic [IDX_W:0] rel;
  logic           consumed;
  logic           live;

  // pos is biased by WIN-1 so out-of-song positions never go negative
  always_comb begin
    win = '0;
    pos = '0;
    rel = '0;
    for (int k = 0; k < WIN; k++) begin
      pos = {1'b0, idx} + (IDX_W+1)'(k);
      rel = pos - LO;
      if (pos >= LO && pos < HI) win[k] = song_bits[rel[SP_W-1:0]];
    end
    if (consumed) win[0] = 1'b0;
  end

  assign live = win[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      consumed <= 1'b0;
      display  <= '0;
      hit_ok   <= 1'b0;
      hit_bad  <= 1'b0;
      miss     <= 1'b0;
    end else begin
      display <= show ? win : '0;
      hit_ok  <= hit & live;
      hit_bad <= hit & ~live;
      // an accepted hit in the same cycle as the advance suppresses the miss
      miss    <= advance & live & ~hit;
      if (clear || advance)   consumed <= 1'b0;
      else if (hit && live)   consumed <= 1'b1;
    end
  end

endmodule

// File: rtl/note_lane_scroller.sv
// Note-highway driver: play-mode FSM and head index, with one window lane per string.
//   state | meaning
//   IDLE  | no song; display dark
//   RUN   | scrolling on beat_tick, judging hits
//   PAUSE | frozen while pause is high
//   DONE  | song finished, idx parked at SONG_LEN+WIN-1
module note_lane_scroller
  import note_disp_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int SONG_LEN = 32,
  parameter int WIN      = 7,
  parameter int IDX_W    = $clog2(SONG_LEN + WIN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                mode,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      beat_tick,
  input  logic [LANES*SONG_LEN-1:0] song,
  input  logic [LANES-1:0]          hit,
  output logic [LANES*WIN-1:0]      display,
  output logic [IDX_W-1:0]          idx,
  output logic                      busy,
  output logic                      done,
  output logic [LANES-1:0]          hit_ok,
  output logic [LANES-1:0]          hit_bad,
  output logic [LANES-1:0]          miss
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN + WIN - 1);
  localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(SONG_LEN + WIN - 2);

  state_t           state, state_n;
  logic             play, judge, advance, start_ok, clear, show;
  logic [LANES-1:0] hit_g;

  assign play     = (mode == PLAY_MODE);
  assign judge    = play && (state == RUN) && !pause;
  assign advance  = judge && beat_tick;
  assign start_ok = play && start && (state == IDLE || state == DONE);
  assign clear    = !play || start_ok;
  assign show     = play && (state != IDLE);
  assign hit_g    = judge ? hit : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!play) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_n = RUN;
        RUN: begin
          if (pause)                               state_n = PAUSE;
          else if (beat_tick && idx == IDX_PRE)    state_n = DONE;
        end
        PAUSE:      if (!pause) state_n = RUN;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                idx <= '0;
    else if (clear)                         idx <= '0;
    else if (advance && idx != IDX_LAST)    idx <= idx + IDX_W'(1);
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_window_lane #(
      .SONG_LEN (SONG_LEN),
      .WIN      (WIN),
      .IDX_W    (IDX_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .song_bits (song[l*SONG_LEN +: SONG_LEN]),
      .hit       (hit_g[l]),
      .advance   (advance),
      .clear     (clear),
      .show      (show),
      .display   (display[l*WIN +: WIN]),
      .hit_ok    (hit_ok[l]),
      .hit_bad   (hit_bad[l]),
      .miss      (miss[l])
    );
  end

endmodule
